// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: read-select encoding and default port width.
// Used by both the address decoder and the port unit.
package gpio_pkg;

    localparam int GPIO_W = 32;

    localparam logic [1:0] RDSEL_IN1  = 2'b00;
    localparam logic [1:0] RDSEL_IN2  = 2'b01;
    localparam logic [1:0] RDSEL_OUT1 = 2'b10;
    localparam logic [1:0] RDSEL_OUT2 = 2'b11;

endpackage

// File: rtl/gpio_port_unit_if.sv
// Decoder-side bus into the GPIO port unit: write strobes, read select and
// data, plus the interrupt line back to the system.
interface gpio_port_unit_if #(
    parameter int W = gpio_pkg::GPIO_W
);
    logic         WE1;
    logic         WE2;
    logic         RE;
    logic [1:0]   RdSel;
    logic [W-1:0] WD;
    logic [W-1:0] RD;
    logic         irq;

    modport master (
        output WE1, WE2, RE, RdSel, WD,
        input  RD, irq
    );

    modport slave (
        input  WE1, WE2, RE, RdSel, WD,
        output RD, irq
    );
endinterface

// File: rtl/gpio_sync.sv
// W-bit wide, STAGES-deep synchronizer chain for an asynchronous input port.
// STAGES must be 2 or more; q is the last stage.
module gpio_sync #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/gpio_port_unit.sv
// GPIO register/pin stage: two output registers, two synchronized input
// ports and registered read data. Optional edge irq via GPIO_EDGE_IRQ_EN.
module gpio_port_unit
    import gpio_pkg::*;
#(
    parameter int W           = GPIO_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_port_unit_if.slave  bus,
    input  logic [W-1:0]     gpI1,
    input  logic [W-1:0]     gpI2,
    output logic [W-1:0]     gpO1,
    output logic [W-1:0]     gpO2
);

    logic [W-1:0] s1, s2;
    logic [W-1:0] rd_q;

    gpio_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync1 (
        .clk (clk),
        .rst (rst),
        .d   (gpI1),
        .q   (s1)
    );

    gpio_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (gpI2),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            gpO1 <= '0;
            gpO2 <= '0;
        end else begin
            if (bus.WE1) gpO1 <= bus.WD;
            if (bus.WE2) gpO2 <= bus.WD;
        end
    end

    // Mux reads the registers' current value, so a same-cycle write shows up
    // only on the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            case (bus.RdSel)
                RDSEL_IN1:  rd_q <= s1;
                RDSEL_IN2:  rd_q <= s2;
                RDSEL_OUT1: rd_q <= gpO1;
                default:    rd_q <= gpO2;
            endcase
        end
    end

    assign bus.RD = rd_q;

`ifdef GPIO_EDGE_IRQ_EN
    logic [W-1:0] s1_prev;
    logic [W-1:0] edge_st;
    logic         irq_q;
    logic         edge_clr;

    assign edge_clr = bus.RE && (bus.RdSel == RDSEL_IN1);

    // A rising edge in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_prev <= '0;
            edge_st <= '0;
            irq_q   <= 1'b0;
        end else begin
            s1_prev <= s1;
            edge_st <= (edge_clr ? '0 : edge_st) | (s1 & ~s1_prev);
            irq_q   <= |edge_st;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unused_re;
    assign unused_re = bus.RE;
    assign bus.irq   = 1'b0;
`endif

endmodule

// File: doc/gpio_port_unit.md
Name: gpio_port_unit

Overview:
- Register and pin stage directly downstream of the GPIO address decoder.
- Consumes the decoder's WE1, WE2 and RdSel outputs plus the CPU write data.
- Holds the two GPIO output registers, synchronizes the two external input ports, and returns registered read data to the system read mux.
- Optional rising-edge interrupt on input port 1.

Parameters:
- W, 32, data width of every GPIO port and of WD/RD.
- SYNC_STAGES, 2, flop depth of each input synchronizer; legal values are 2 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; see interface note below.
- WE1  in  1  write strobe for output register gpO1.
- WE2  in  1  write strobe for output register gpO2.
- RdSel  in  2  read select: 00 gpI1, 01 gpI2, 10 gpO1, 11 gpO2.
- RE  in  1  read strobe; qualifies side-effecting reads.
- WD  in  W  CPU write data.
- gpI1  in  W  external input port 1; asynchronous to clk.
- gpI2  in  W  external input port 2; asynchronous to clk.
- gpO1  out  W  output register 1, drives pins.
- gpO2  out  W  output register 2, drives pins.
- RD  out  W  registered read data.
- irq  out  1  level interrupt; see Optional Feature.

Interface note:
- One clock, clk.
- Reset rst is synchronous and active-high.
- Nothing in the block changes asynchronously.

Behaviour:
- Reset (rst=1 at a clk edge):
  - gpO1, gpO2, RD, all synchronizer flops, edge status and irq all become 0.
  - rst has priority over every strobe in that cycle.
  - Asserting rst mid-operation discards any pending write or edge.
- Writes:
  - WE1=1 at the edge loads gpO1<=WD; WE2=1 loads gpO2<=WD.
  - Both strobes high loads both registers with WD.
  - No strobe: registers hold.
- Input synchronizers:
  - Each input bit passes through SYNC_STAGES flops; the last stage is called s1 for gpI1 and s2 for gpI2.
  - A pin change becomes visible in s1/s2 exactly SYNC_STAGES edges later.
- Read path:
  - RD<=mux(RdSel) every cycle, regardless of RE: 00 s1, 01 s2, 10 gpO1, 11 gpO2.
  - RD is valid one cycle after RdSel is applied.
  - A read of gpO1/gpO2 in the same cycle as a write to it returns the pre-write value; the new value appears on the following read.
- Width: all data paths are exactly W bits; there is no extension or truncation.
- No handshake back-pressure: the block accepts one write and one read select every cycle.

Optional Feature:
- Macro: GPIO_EDGE_IRQ_EN.
- With the macro defined:
  - A W-bit sticky register edge_st is added.
  - Each cycle, edge_st |= s1 & ~s1_prev, where s1_prev is s1 delayed one cycle and is reset to 0.
  - irq = |edge_st, registered, so it asserts one cycle after the edge bit sets.
  - RE=1 with RdSel=00 clears edge_st at that edge.
  - If a new rising edge arrives in the clearing cycle, set wins for that bit.
- Without the macro:
  - No edge logic is built.
  - irq is tied to 0.
  - RE is ignored.

Decomposition:
- Package gpio_pkg:
  - RdSel encoding constants RDSEL_IN1=2'b00, RDSEL_IN2=2'b01, RDSEL_OUT1=2'b10, RDSEL_OUT2=2'b11.
  - Default width constant GPIO_W=32.
  - The decoder and this block share it.
- Sub-module gpio_sync:
  - Parameterized W x SYNC_STAGES flop chain with synchronous reset.
  - Instantiated once for gpI1 and once for gpI2.

Test Plan:
- Reset: drive rst for 2 cycles with gpI1=0xFFFFFFFF -> gpO1=gpO2=RD=0 and irq=0 while rst=1.
- Write/readback: WE1=1, WD=0xDEADBEEF; next cycle WE2=1, WD=0x12345678; then RdSel=10 then 11 -> gpO1=0xDEADBEEF, gpO2=0x12345678, RD shows each value one cycle after its select.
- Read-during-write: gpO1=0x1, then WE1=1, WD=0x2 with RdSel=10 in the same cycle -> RD=0x1 next cycle, RD=0x2 the cycle after.
- Sync latency: gpI2 steps 0->0x00000055 with RdSel=01 held -> RD still 0 for SYNC_STAGES edges after the step, then 0x55 one cycle later (SYNC_STAGES+1 total).
- Dual write: WE1=WE2=1, WD=0xA5A5A5A5 -> both outputs 0xA5A5A5A5; rst asserted in the same cycle -> both 0.
- With GPIO_EDGE_IRQ_EN:
  - gpI1 bit0 rises -> irq=1 at SYNC_STAGES+2 cycles.
  - RE=1 with RdSel=00 -> irq=0 next cycle.
  - A bit3 edge coincident with the clear -> irq stays 1.
